udma_l2_responder: RTL and testbench
====================================

Name: udma_l2_responder

Overview:
- Memory-side responder for the uDMA's two L2 initiator ports: the read-only TX port and the write-only RX port.
- Terminates the req/gnt/rvalid protocol of both ports on one single-port SRAM macro with 1-cycle read latency.
- Arbitrates the two ports round-robin, decodes the address window, and returns error data for out-of-window accesses.
- Sits between the uDMA subsystem L2 ports and a private L2 bank; also serves as the standalone bench memory.

Parameters:
- MEM_ADDR_WIDTH, 14: SRAM word-address width (64 KiB at 32-bit words).
- BASE_ADDR, 32'h1C00_0000: byte base of the served window; aligned to 2^(MEM_ADDR_WIDTH+2).
- DATA_WIDTH, L2_DATA_WIDTH (32): data width; byte enables are DATA_WIDTH/8.

Ports:
- sys_clk_i  in  1  clock
- sys_rst_i  in  1  synchronous, active-high reset
- L2_ro_req_i  in  1  read request
- L2_ro_gnt_o  out  1  read grant, same cycle
- L2_ro_addr_i  in  32  read byte address
- L2_ro_wen_i  in  1  ignored (port is read-only)
- L2_ro_be_i  in  DATA_WIDTH/8  ignored
- L2_ro_wdata_i  in  DATA_WIDTH  ignored
- L2_ro_rvalid_o  out  1  read response valid
- L2_ro_rdata_o  out  DATA_WIDTH  read data
- L2_wo_req_i  in  1  write request
- L2_wo_gnt_o  out  1  write grant
- L2_wo_addr_i  in  32  write byte address
- L2_wo_wen_i  in  1  ignored (port is write-only)
- L2_wo_be_i  in  DATA_WIDTH/8  byte enables
- L2_wo_wdata_i  in  DATA_WIDTH  write data
- L2_wo_rvalid_o  out  1  write ack
- L2_wo_rdata_o  out  DATA_WIDTH  constant 0
- mem_req_o  out  1  SRAM access
- mem_we_o  out  1  1 = write
- mem_addr_o  out  MEM_ADDR_WIDTH  word address
- mem_be_o  out  DATA_WIDTH/8  byte enables
- mem_wdata_o  out  DATA_WIDTH  write data
- mem_rdata_i  in  DATA_WIDTH  valid the cycle after a read mem_req_o
- err_o  out  1  1-cycle pulse on an out-of-window access
- stats_ro_o, stats_wo_o, stats_stall_o  out  32 each  counters (see Optional Feature)

Behaviour:
- Reset, and every cycle sys_rst_i=1:
  - gnt, rvalid, mem_req_o and err_o are 0.
  - rdata outputs are 0.
  - rr_q=0, meaning ro has priority.
  - All pending responses are dropped; no rvalid is issued for a grant made in the cycle before reset.
- Grant:
  - Combinational, at most one port per cycle; one access per cycle, back-to-back, no bubbles.
  - A lone requester is granted immediately.
  - Both requesting: rr_q=0 grants ro, rr_q=1 grants wo.
  - On every grant, rr_q <= (granted==ro); the other port then wins the next conflict.
  - The ungranted requester holds req/addr/data stable; stability is checked by assertion only.
- In-window test: addr[31:MEM_ADDR_WIDTH+2] == BASE_ADDR[31:MEM_ADDR_WIDTH+2]. Word address = addr[MEM_ADDR_WIDTH+1:2]. Low two address bits are ignored.
- Granted in-window ro access:
  - mem_req_o=1, mem_we_o=0, mem_be_o=all ones.
  - Next cycle: L2_ro_rvalid_o=1, L2_ro_rdata_o=mem_rdata_i.
- Granted in-window wo access:
  - mem_req_o=1, mem_we_o=1, be/wdata forwarded.
  - Next cycle: L2_wo_rvalid_o=1, L2_wo_rdata_o=0.
- Granted out-of-window access:
  - mem_req_o=0; err_o=1 in the cycle after the grant.
  - rvalid follows next cycle as normal; ro rdata = L2_RESP_ERR_RDATA (32'hBADA_CCE5); writes are discarded.
- Latency: gnt to rvalid is exactly 1 cycle. rvalid is registered; rdata is muxed from a registered source select.
- Simultaneous events: a new grant in the same cycle as the previous rvalid is legal; fully pipelined.

Optional Feature:
- Macro: UDMA_L2_RESP_STATS_EN.
- Defined: three 32-bit counters, all cleared by reset and saturating at 32'hFFFF_FFFF (no wrap):
  - stats_ro_o: ro grants.
  - stats_wo_o: wo grants.
  - stats_stall_o: cycles where a port requested and was not granted.
- Undefined: the ports still exist, tied to 0, and no counter flops are built.

Decomposition:
- Shared package udma_pkg gains:
  - L2_RESP_ERR_RDATA constant.
  - typedef l2_port_sel_e {L2_SEL_RO, L2_SEL_WO}.
  - typedef l2_req_t struct (req, addr, be, wdata).
- Sub-module udma_l2_rr_arb: 2-way round-robin arbiter.
  - Inputs: req[1:0].
  - Outputs: gnt[1:0], sel.
  - Holds rr_q internally; same sync active-high reset.

Test Plan:
- ro read of BASE+0x10, memory word 4 = 32'hCAFE_F00D -> same-cycle gnt; mem_addr_o=4, mem_we_o=0; next cycle ro rvalid=1, rdata=32'hCAFE_F00D.
- wo write of BASE+0x8, wdata 32'h1234_5678, be 4'b0011 -> mem_we_o=1, mem_addr_o=2, mem_be_o=4'b0011; next cycle wo rvalid=1; readback of word 2 shows low half written only.
- Both ports requesting continuously for 6 cycles from reset -> grants ro,wo,ro,wo,ro,wo; each rvalid exactly 1 cycle after its grant; stats_stall_o=6 with UDMA_L2_RESP_STATS_EN.
- ro read at 32'h1A00_0000 -> gnt=1, mem_req_o=0, err_o pulse, next-cycle rdata=32'hBADA_CCE5; wo write out-of-window -> memory unchanged, wo rvalid=1.
- Grant ro, then assert sys_rst_i the following cycle -> no rvalid; rr_q back to 0, so the next conflict grants ro.
- Stats build, counter preloaded near max via force, 3 more ro grants -> stats_ro_o holds 32'hFFFF_FFFF; without the macro all stats outputs read 0.

Source files
------------

// File: rtl/udma_pkg.sv
// Shared uDMA definitions used by the L2 responder and its arbiter.
package udma_pkg;

  localparam int L2_DATA_WIDTH = 32;

  // Data returned to the read port for accesses outside the served window.
  localparam logic [31:0] L2_RESP_ERR_RDATA = 32'hBADA_CCE5;

  typedef enum logic {
    L2_SEL_RO = 1'b0,
    L2_SEL_WO = 1'b1
  } l2_port_sel_e;

  typedef struct packed {
    logic                       req;
    logic [31:0]                addr;
    logic [L2_DATA_WIDTH/8-1:0] be;
    logic [L2_DATA_WIDTH-1:0]   wdata;
  } l2_req_t;

endpackage

// File: rtl/udma_l2_rr_arb.sv
// Two-way round-robin arbiter for the uDMA L2 ports (bit 0 = ro, bit 1 = wo).
// rr_q=0 gives ro priority on a conflict, rr_q=1 gives wo priority.
module udma_l2_rr_arb
  import udma_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req,
  output logic [1:0]   gnt,
  output l2_port_sel_e sel
);

  logic rr_q;

  // Pick one requester: a lone requester always wins, a conflict goes by rr_q.
  always_comb begin
    gnt = 2'b00;
    sel = L2_SEL_RO;
    if (req[0] && (!req[1] || !rr_q)) begin
      gnt = 2'b01;
      sel = L2_SEL_RO;
    end else if (req[1]) begin
      gnt = 2'b10;
      sel = L2_SEL_WO;
    end
  end

  // After any grant, the other port wins the next conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= 1'b0;
    end else if (|gnt) begin
      rr_q <= (sel == L2_SEL_RO);
    end
  end

endmodule

// File: rtl/udma_l2_responder.sv
// L2 responder terminating the uDMA ro (read) and wo (write) ports on a
// single-port SRAM with 1-cycle read latency. Accesses outside the window
// starting at BASE_ADDR are not sent to the SRAM; they raise err_o and
// complete with error read data (reads) or are discarded (writes).
// Optional access counters are built when UDMA_L2_RESP_STATS_EN is defined;
// otherwise the stats outputs are tied to zero.
module udma_l2_responder
  import udma_pkg::*;
#(
  parameter int          MEM_ADDR_WIDTH = 14,
  parameter logic [31:0] BASE_ADDR      = 32'h1C00_0000,
  parameter int          DATA_WIDTH     = L2_DATA_WIDTH
) (
  input  logic                      sys_clk_i,
  input  logic                      sys_rst_i,

  input  logic                      L2_ro_req_i,
  output logic                      L2_ro_gnt_o,
  input  logic [31:0]               L2_ro_addr_i,
  input  logic                      L2_ro_wen_i,
  input  logic [DATA_WIDTH/8-1:0]   L2_ro_be_i,
  input  logic [DATA_WIDTH-1:0]     L2_ro_wdata_i,
  output logic                      L2_ro_rvalid_o,
  output logic [DATA_WIDTH-1:0]     L2_ro_rdata_o,

  input  logic                      L2_wo_req_i,
  output logic                      L2_wo_gnt_o,
  input  logic [31:0]               L2_wo_addr_i,
  input  logic                      L2_wo_wen_i,
  input  logic [DATA_WIDTH/8-1:0]   L2_wo_be_i,
  input  logic [DATA_WIDTH-1:0]     L2_wo_wdata_i,
  output logic                      L2_wo_rvalid_o,
  output logic [DATA_WIDTH-1:0]     L2_wo_rdata_o,

  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH/8-1:0]   mem_be_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i,

  output logic                      err_o,
  output logic [31:0]               stats_ro_o,
  output logic [31:0]               stats_wo_o,
  output logic [31:0]               stats_stall_o
);

  localparam int WIN_LSB = MEM_ADDR_WIDTH + 2;

  l2_req_t      ro_req;
  l2_req_t      wo_req;
  l2_req_t      sel_req;
  logic [1:0]   arb_req;
  logic [1:0]   arb_gnt;
  l2_port_sel_e arb_sel;
  logic         any_gnt;
  logic         in_win;

  logic         ro_rvalid_q;
  logic         wo_rvalid_q;
  logic         err_q;

  // The read port always reads full words; its be/wdata/wen are don't-care.
  assign ro_req = '{req: L2_ro_req_i, addr: L2_ro_addr_i, be: '1, wdata: '0};
  assign wo_req = '{req: L2_wo_req_i, addr: L2_wo_addr_i, be: L2_wo_be_i,
                    wdata: L2_wo_wdata_i};

  // Holding requests off during reset keeps grants low and rr_q untouched.
  assign arb_req = sys_rst_i ? 2'b00 : {wo_req.req, ro_req.req};

  udma_l2_rr_arb u_arb (
    .clk (sys_clk_i),
    .rst (sys_rst_i),
    .req (arb_req),
    .gnt (arb_gnt),
    .sel (arb_sel)
  );

  assign L2_ro_gnt_o = arb_gnt[0];
  assign L2_wo_gnt_o = arb_gnt[1];
  assign any_gnt     = |arb_gnt;
  assign sel_req     = (arb_sel == L2_SEL_WO) ? wo_req : ro_req;
  assign in_win      = (sel_req.addr[31:WIN_LSB] == BASE_ADDR[31:WIN_LSB]);

  assign mem_req_o   = any_gnt && in_win;
  assign mem_we_o    = mem_req_o && (arb_sel == L2_SEL_WO);
  assign mem_addr_o  = sel_req.addr[WIN_LSB-1:2];
  assign mem_be_o    = sel_req.be;
  assign mem_wdata_o = sel_req.wdata;

  // Response pipeline: one stage from grant to rvalid, err tags the same access.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      ro_rvalid_q <= 1'b0;
      wo_rvalid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      ro_rvalid_q <= arb_gnt[0];
      wo_rvalid_q <= arb_gnt[1];
      err_q       <= any_gnt && !in_win;
    end
  end

  // Responses are masked while reset is high so a grant made just before
  // reset never produces an rvalid.
  assign L2_ro_rvalid_o = ro_rvalid_q && !sys_rst_i;
  assign L2_wo_rvalid_o = wo_rvalid_q && !sys_rst_i;
  assign err_o          = err_q && !sys_rst_i;
  assign L2_ro_rdata_o  = !L2_ro_rvalid_o ? '0 :
                          err_q ? DATA_WIDTH'(L2_RESP_ERR_RDATA) : mem_rdata_i;
  assign L2_wo_rdata_o  = '0;

  logic unused_inputs;
  assign unused_inputs = ^{L2_ro_wen_i, L2_ro_be_i, L2_ro_wdata_i, L2_wo_wen_i,
                           sel_req.req, sel_req.addr[1:0]};

`ifdef UDMA_L2_RESP_STATS_EN
  logic [31:0] stats_ro_q;
  logic [31:0] stats_wo_q;
  logic [31:0] stats_stall_q;
  logic        stall;

  // A conflict stalls exactly one port, so this counts stalled cycles.
  assign stall = (arb_req[0] && !arb_gnt[0]) || (arb_req[1] && !arb_gnt[1]);

  // Saturating event counters.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      stats_ro_q    <= '0;
      stats_wo_q    <= '0;
      stats_stall_q <= '0;
    end else begin
      if (arb_gnt[0] && (stats_ro_q != 32'hFFFF_FFFF))    stats_ro_q    <= stats_ro_q + 32'd1;
      if (arb_gnt[1] && (stats_wo_q != 32'hFFFF_FFFF))    stats_wo_q    <= stats_wo_q + 32'd1;
      if (stall && (stats_stall_q != 32'hFFFF_FFFF))      stats_stall_q <= stats_stall_q + 32'd1;
    end
  end

  assign stats_ro_o    = stats_ro_q;
  assign stats_wo_o    = stats_wo_q;
  assign stats_stall_o = stats_stall_q;
`else
  assign stats_ro_o    = '0;
  assign stats_wo_o    = '0;
  assign stats_stall_o = '0;
`endif

`ifndef SYNTHESIS
  // A stalled requester must keep its request and payload unchanged.
  ro_hold_a: assert property (@(posedge sys_clk_i) disable iff (sys_rst_i)
    (L2_ro_req_i && !L2_ro_gnt_o) |=> (L2_ro_req_i && $stable(L2_ro_addr_i)));
  wo_hold_a: assert property (@(posedge sys_clk_i) disable iff (sys_rst_i)
    (L2_wo_req_i && !L2_wo_gnt_o) |=> (L2_wo_req_i && $stable(L2_wo_addr_i)
      && $stable(L2_wo_be_i) && $stable(L2_wo_wdata_i)));
`endif

endmodule

// File: tb/tb_udma_l2_responder.sv
// Directed bench for udma_l2_responder with a behavioural 1-cycle SRAM.
// Stats checks follow UDMA_L2_RESP_STATS_EN.
module tb_udma_l2_responder;
  import udma_pkg::*;

  localparam logic [31:0] BASE = 32'h1C00_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ro_req = 1'b0, wo_req = 1'b0;
  logic [31:0] ro_addr = '0, wo_addr = '0, wo_wdata = '0;
  logic [3:0]  wo_be = '0;
  logic        ro_gnt, wo_gnt, ro_rvalid, wo_rvalid, err;
  logic [31:0] ro_rdata, wo_rdata;
  logic        mem_req, mem_we;
  logic [13:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [31:0] st_ro, st_wo, st_stall;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [0:16383];

  always #5 clk = ~clk;

  udma_l2_responder dut (
    .sys_clk_i(clk), .sys_rst_i(rst),
    .L2_ro_req_i(ro_req), .L2_ro_gnt_o(ro_gnt), .L2_ro_addr_i(ro_addr),
    .L2_ro_wen_i(1'b0), .L2_ro_be_i(4'h0), .L2_ro_wdata_i(32'h0),
    .L2_ro_rvalid_o(ro_rvalid), .L2_ro_rdata_o(ro_rdata),
    .L2_wo_req_i(wo_req), .L2_wo_gnt_o(wo_gnt), .L2_wo_addr_i(wo_addr),
    .L2_wo_wen_i(1'b1), .L2_wo_be_i(wo_be), .L2_wo_wdata_i(wo_wdata),
    .L2_wo_rvalid_o(wo_rvalid), .L2_wo_rdata_o(wo_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_be_o(mem_be), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .err_o(err), .stats_ro_o(st_ro), .stats_wo_o(st_wo), .stats_stall_o(st_stall)
  );

  // Behavioural SRAM: byte-enabled writes, registered read data.
  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ro_req = 1'b1; ro_addr = BASE + 32'h10;
    wo_req = 1'b1; wo_addr = BASE + 32'h20;
    step(); step();
    #1;
    n_tests++; if ({ro_gnt, wo_gnt} !== 2'b00) begin n_fail++; $display("FAIL reset_gnt got %b want 00", {ro_gnt, wo_gnt}); end
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
    n_tests++; if ({ro_rvalid, wo_rvalid, err} !== 3'b000) begin n_fail++; $display("FAIL reset_rvalid_err got %b want 000", {ro_rvalid, wo_rvalid, err}); end
    n_tests++; if (ro_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", ro_rdata); end
    n_tests++; if ({st_ro, st_wo, st_stall} !== 96'h0) begin n_fail++; $display("FAIL reset_stats got %h/%h/%h want 0", st_ro, st_wo, st_stall); end
    ro_req = 1'b0; wo_req = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_read();
    step();
    ro_req = 1'b1; ro_addr = BASE + 32'h10;
    #1;
    n_tests++; if ({ro_gnt, wo_gnt} !== 2'b10) begin n_fail++; $display("FAIL read_gnt got %b want 10", {ro_gnt, wo_gnt}); end
    n_tests++; if ({mem_req, mem_we} !== 2'b10) begin n_fail++; $display("FAIL read_mem_req_we got %b want 10", {mem_req, mem_we}); end
    n_tests++; if (mem_addr !== 14'd4) begin n_fail++; $display("FAIL read_mem_addr got %0d want 4", mem_addr); end
    n_tests++; if (mem_be !== 4'hF) begin n_fail++; $display("FAIL read_mem_be got %h want f", mem_be); end
    step();
    n_tests++; if ({ro_rvalid, wo_rvalid} !== 2'b10) begin n_fail++; $display("FAIL read_rvalid got %b want 10", {ro_rvalid, wo_rvalid}); end
    n_tests++; if (ro_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL read_rdata got %h want cafef00d", ro_rdata); end
    ro_req = 1'b0;
    step();
    n_tests++; if (ro_rvalid !== 1'b0) begin n_fail++; $display("FAIL read_rvalid_drop got %b want 0", ro_rvalid); end
  endtask

  task automatic test_write();
    wo_req = 1'b1; wo_addr = BASE + 32'h8; wo_wdata = 32'h1234_5678; wo_be = 4'b0011;
    #1;
    n_tests++; if ({ro_gnt, wo_gnt} !== 2'b01) begin n_fail++; $display("FAIL write_gnt got %b want 01", {ro_gnt, wo_gnt}); end
    n_tests++; if ({mem_req, mem_we} !== 2'b11) begin n_fail++; $display("FAIL write_mem_req_we got %b want 11", {mem_req, mem_we}); end
    n_tests++; if (mem_addr !== 14'd2) begin n_fail++; $display("FAIL write_mem_addr got %0d want 2", mem_addr); end
    n_tests++; if (mem_be !== 4'b0011 || mem_wdata !== 32'h1234_5678) begin n_fail++; $display("FAIL write_be_wdata got %b/%h want 0011/12345678", mem_be, mem_wdata); end
    step();
    n_tests++; if ({ro_rvalid, wo_rvalid} !== 2'b01) begin n_fail++; $display("FAIL write_rvalid got %b want 01", {ro_rvalid, wo_rvalid}); end
    n_tests++; if (wo_rdata !== 32'h0) begin n_fail++; $display("FAIL write_rdata got %h want 0", wo_rdata); end
    wo_req = 1'b0;
    ro_req = 1'b1; ro_addr = BASE + 32'h8;
    step();
    ro_req = 1'b0;
    n_tests++; if (ro_rdata !== 32'hAAAA_5678) begin n_fail++; $display("FAIL write_readback got %h want aaaa5678", ro_rdata); end
  endtask

  task automatic test_back_to_back();
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    ro_req = 1'b1; ro_addr = BASE + 32'h10;
    wo_req = 1'b1; wo_addr = BASE + 32'h20; wo_wdata = 32'h0000_0055; wo_be = 4'hF;
    for (int k = 0; k < 6; k++) begin
      #1;
      n_tests++; if ({ro_gnt, wo_gnt} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL b2b_gnt[%0d] got %b want %b", k, {ro_gnt, wo_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01); end
      step();
      n_tests++; if ({ro_rvalid, wo_rvalid} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL b2b_rvalid[%0d] got %b want %b", k, {ro_rvalid, wo_rvalid}, (k % 2 == 0) ? 2'b10 : 2'b01); end
    end
    wo_req = 1'b0;
`ifdef UDMA_L2_RESP_STATS_EN
    n_tests++; if (st_stall !== 32'd6) begin n_fail++; $display("FAIL b2b_stall got %0d want 6", st_stall); end
    n_tests++; if (st_ro !== 32'd3 || st_wo !== 32'd3) begin n_fail++; $display("FAIL b2b_grant_counts got %0d/%0d want 3/3", st_ro, st_wo); end
`endif
    #1;
    n_tests++; if (ro_gnt !== 1'b1) begin n_fail++; $display("FAIL b2b_tail_gnt got %b want 1", ro_gnt); end
    step();
    ro_req = 1'b0;
    n_tests++; if (ro_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL b2b_tail_rdata got %h want cafef00d", ro_rdata); end
  endtask

  task automatic test_out_of_window();
    ro_req = 1'b1; ro_addr = 32'h1A00_0000;
    #1;
    n_tests++; if ({ro_gnt, mem_req, err} !== 3'b100) begin n_fail++; $display("FAIL oow_rd_issue got %b want 100", {ro_gnt, mem_req, err}); end
    step();
    n_tests++; if ({err, ro_rvalid} !== 2'b11) begin n_fail++; $display("FAIL oow_rd_err_rvalid got %b want 11", {err, ro_rvalid}); end
    n_tests++; if (ro_rdata !== 32'hBADA_CCE5) begin n_fail++; $display("FAIL oow_rd_rdata got %h want badacce5", ro_rdata); end
    ro_req = 1'b0;
    wo_req = 1'b1; wo_addr = 32'h1A00_0010; wo_wdata = 32'hFFFF_FFFF; wo_be = 4'hF;
    #1;
    n_tests++; if ({wo_gnt, mem_req} !== 2'b10) begin n_fail++; $display("FAIL oow_wr_issue got %b want 10", {wo_gnt, mem_req}); end
    step();
    n_tests++; if ({err, wo_rvalid} !== 2'b11) begin n_fail++; $display("FAIL oow_wr_err_rvalid got %b want 11", {err, wo_rvalid}); end
    wo_req = 1'b0;
    ro_req = 1'b1; ro_addr = BASE + 32'h10;
    step();
    ro_req = 1'b0;
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL oow_err_pulse got %b want 0", err); end
    n_tests++; if (ro_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL oow_mem_unchanged got %h want cafef00d", ro_rdata); end
  endtask

  task automatic test_reset_drop();
    ro_req = 1'b1; ro_addr = BASE + 32'h10;
    #1;
    n_tests++; if (ro_gnt !== 1'b1) begin n_fail++; $display("FAIL rstdrop_gnt got %b want 1", ro_gnt); end
    step();
    rst = 1'b1; ro_req = 1'b0;
    #1;
    n_tests++; if ({ro_rvalid, err} !== 2'b00 || ro_rdata !== 32'h0) begin n_fail++; $display("FAIL rstdrop_rvalid got %b/%h want 0/0", ro_rvalid, ro_rdata); end
    step();
    rst = 1'b0;
    n_tests++; if (ro_rvalid !== 1'b0) begin n_fail++; $display("FAIL rstdrop_after got %b want 0", ro_rvalid); end
    ro_req = 1'b1; ro_addr = BASE + 32'h10;
    wo_req = 1'b1; wo_addr = BASE + 32'h20; wo_wdata = 32'h0; wo_be = 4'hF;
    #1;
    n_tests++; if ({ro_gnt, wo_gnt} !== 2'b10) begin n_fail++; $display("FAIL rstdrop_rr_gnt got %b want 10", {ro_gnt, wo_gnt}); end
    step();
    ro_req = 1'b0;
    #1;
    n_tests++; if (wo_gnt !== 1'b1) begin n_fail++; $display("FAIL rstdrop_wo_gnt got %b want 1", wo_gnt); end
    step();
    wo_req = 1'b0;
    n_tests++; if (wo_rvalid !== 1'b1) begin n_fail++; $display("FAIL rstdrop_wo_rvalid got %b want 1", wo_rvalid); end
  endtask

  task automatic test_stats();
`ifdef UDMA_L2_RESP_STATS_EN
    step();
    force dut.stats_ro_q = 32'hFFFF_FFFD;
    #1;
    release dut.stats_ro_q;
    ro_req = 1'b1; ro_addr = BASE + 32'h10;
    step(); step(); step();
    ro_req = 1'b0;
    n_tests++; if (st_ro !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL stats_saturate got %h want ffffffff", st_ro); end
    step();
    n_tests++; if (st_ro !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL stats_hold got %h want ffffffff", st_ro); end
`else
    step();
    n_tests++; if (st_ro !== 32'h0) begin n_fail++; $display("FAIL stats_ro_tied got %h want 0", st_ro); end
    n_tests++; if (st_wo !== 32'h0) begin n_fail++; $display("FAIL stats_wo_tied got %h want 0", st_wo); end
    n_tests++; if (st_stall !== 32'h0) begin n_fail++; $display("FAIL stats_stall_tied got %h want 0", st_stall); end
`endif
  endtask

  initial begin
    mem[2] = 32'hAAAA_BBBB;
    mem[4] = 32'hCAFE_F00D;
    mem[8] = 32'h0000_0000;
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_out_of_window();
    test_reset_drop();
    test_stats();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
